// File: rtl/ram_march_bist.sv
// ram_march_bist: four-phase march BIST for a dual-port RAM. Port A covers the
// lower half and port B the upper half. The test writes a background, reads it
// back, writes an address pattern, then cross-reads it through the other port.
// The first mismatch is recorded, with port A winning a same-cycle tie.
module ram_march_bist #(
  parameter int unsigned       ADDR_W = 7,
  parameter int unsigned       DATA_W = 8,
  parameter int unsigned       RD_LAT = 1,
  parameter logic [DATA_W-1:0] BG     = DATA_W'(8'h55)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail_port,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic [DATA_W-1:0] fail_exp,
  output logic [ADDR_W-1:0] a1,
  output logic [DATA_W-1:0] d1,
  output logic              wr1,
  input  logic [DATA_W-1:0] q1,
  output logic [ADDR_W-1:0] a2,
  output logic [DATA_W-1:0] d2,
  output logic              wr2,
  input  logic [DATA_W-1:0] q2
);

  localparam int unsigned       H         = 1 << (ADDR_W - 1);
  localparam logic [ADDR_W-1:0] K_H       = ADDR_W'(H);
  localparam logic [ADDR_W-1:0] K_LAST_WR = ADDR_W'(H - 1);
  localparam logic [ADDR_W-1:0] K_LAST_RD = ADDR_W'(H + RD_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_BG, S_RD_BG, S_WR_AD, S_RD_X, S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] k_q, k_d;

  logic              busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic              fail_port_q, fail_port_d;
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
  logic [DATA_W-1:0] fail_data_q, fail_data_d, fail_exp_q, fail_exp_d;
  logic [ADDR_W-1:0] a1_q, a1_d, a2_q, a2_d;
  logic [DATA_W-1:0] d1_q, d1_d, d2_q, d2_d;
  logic              wr1_q, wr1_d, wr2_q, wr2_d;
  logic              rd_q, rd_d;
  logic [DATA_W-1:0] exp1_q, exp1_d, exp2_q, exp2_d;

  logic [RD_LAT-1:0] pv_q;
  logic [ADDR_W-1:0] pa1_q [RD_LAT];
  logic [ADDR_W-1:0] pa2_q [RD_LAT];
  logic [DATA_W-1:0] pe1_q [RD_LAT];
  logic [DATA_W-1:0] pe2_q [RD_LAT];

  logic              cmp_en_c, mism1_c, mism2_c, mism_c;
  logic [ADDR_W-1:0] lo_c, hi_c;

  function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] x);
    return DATA_W'(x) ^ ~BG;
  endfunction

  // Compare read returns against the pipelined expectation during read phases.
  assign cmp_en_c = pv_q[RD_LAT-1] && (state_q == S_RD_BG || state_q == S_RD_X);
  assign mism1_c  = cmp_en_c && (q1 != pe1_q[RD_LAT-1]);
  assign mism2_c  = cmp_en_c && (q2 != pe2_q[RD_LAT-1]);
  assign mism_c   = mism1_c || mism2_c;

  assign lo_c = {1'b0, k_d[ADDR_W-2:0]};
  assign hi_c = {1'b1, k_d[ADDR_W-2:0]};

  // State and phase index register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  // Phase sequencing; a mismatch cuts the run short.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      S_IDLE: if (start) begin state_d = S_WR_BG; k_d = '0; end
      S_WR_BG:
        if (k_q == K_LAST_WR) begin state_d = S_RD_BG; k_d = '0; end
        else k_d = k_q + ADDR_W'(1);
      S_RD_BG:
        if (mism_c) begin state_d = S_DONE; k_d = '0; end
        else if (k_q == K_LAST_RD) begin state_d = S_WR_AD; k_d = '0; end
        else k_d = k_q + ADDR_W'(1);
      S_WR_AD:
        if (k_q == K_LAST_WR) begin state_d = S_RD_X; k_d = '0; end
        else k_d = k_q + ADDR_W'(1);
      S_RD_X:
        if (mism_c || k_q == K_LAST_RD) begin state_d = S_DONE; k_d = '0; end
        else k_d = k_q + ADDR_W'(1);
      S_DONE:  begin state_d = S_IDLE; k_d = '0; end
      default: begin state_d = S_IDLE; k_d = '0; end
    endcase
  end

  // Next values of the registered outputs, derived from the upcoming state.
  always_comb begin
    busy_d = 1'b0; done_d = 1'b0; rd_d = 1'b0;
    a1_d = '0; d1_d = '0; wr1_d = 1'b0; exp1_d = '0;
    a2_d = '0; d2_d = '0; wr2_d = 1'b0; exp2_d = '0;
    pass_d      = pass_q;
    fail_port_d = fail_port_q;
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;
    fail_exp_d  = fail_exp_q;
    case (state_d)
      S_WR_BG: begin
        busy_d = 1'b1;
        a1_d = lo_c; d1_d = BG; wr1_d = 1'b1;
        a2_d = hi_c; d2_d = BG; wr2_d = 1'b1;
      end
      S_RD_BG: begin
        busy_d = 1'b1;
        if (k_d < K_H) begin
          rd_d = 1'b1;
          a1_d = lo_c; exp1_d = BG;
          a2_d = hi_c; exp2_d = BG;
        end
      end
      S_WR_AD: begin
        busy_d = 1'b1;
        a1_d = lo_c; d1_d = pat(lo_c); wr1_d = 1'b1;
        a2_d = hi_c; d2_d = pat(hi_c); wr2_d = 1'b1;
      end
      S_RD_X: begin
        busy_d = 1'b1;
        if (k_d < K_H) begin
          rd_d = 1'b1;
          a1_d = hi_c; exp1_d = pat(hi_c);
          a2_d = lo_c; exp2_d = pat(lo_c);
        end
      end
      S_DONE:  done_d = 1'b1;
      default: ;
    endcase
    if (state_q == S_IDLE && start) begin
      pass_d = 1'b0; fail_port_d = 1'b0; fail_addr_d = '0;
      fail_data_d = '0; fail_exp_d = '0;
    end
    if (mism1_c) begin
      fail_port_d = 1'b0; fail_addr_d = pa1_q[RD_LAT-1];
      fail_data_d = q1;   fail_exp_d  = pe1_q[RD_LAT-1];
    end else if (mism2_c) begin
      fail_port_d = 1'b1; fail_addr_d = pa2_q[RD_LAT-1];
      fail_data_d = q2;   fail_exp_d  = pe2_q[RD_LAT-1];
    end
    if (state_q == S_RD_X && state_d == S_DONE && !mism_c) pass_d = 1'b1;
  end

  // Output registers and the read-compare pipeline matching RAM latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0; done_q <= 1'b0; pass_q <= 1'b0;
      fail_port_q <= 1'b0; fail_addr_q <= '0; fail_data_q <= '0; fail_exp_q <= '0;
      a1_q <= '0; d1_q <= '0; wr1_q <= 1'b0; exp1_q <= '0;
      a2_q <= '0; d2_q <= '0; wr2_q <= 1'b0; exp2_q <= '0;
      rd_q <= 1'b0;
      pv_q <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        pa1_q[i] <= '0; pa2_q[i] <= '0; pe1_q[i] <= '0; pe2_q[i] <= '0;
      end
    end else begin
      busy_q <= busy_d; done_q <= done_d; pass_q <= pass_d;
      fail_port_q <= fail_port_d; fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d; fail_exp_q <= fail_exp_d;
      a1_q <= a1_d; d1_q <= d1_d; wr1_q <= wr1_d; exp1_q <= exp1_d;
      a2_q <= a2_d; d2_q <= d2_d; wr2_q <= wr2_d; exp2_q <= exp2_d;
      rd_q <= rd_d;
      pv_q[0]  <= rd_q;
      pa1_q[0] <= a1_q; pe1_q[0] <= exp1_q;
      pa2_q[0] <= a2_q; pe2_q[0] <= exp2_q;
      for (int i = 1; i < RD_LAT; i++) begin
        pv_q[i]  <= pv_q[i-1];
        pa1_q[i] <= pa1_q[i-1]; pe1_q[i] <= pe1_q[i-1];
        pa2_q[i] <= pa2_q[i-1]; pe2_q[i] <= pe2_q[i-1];
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_port = fail_port_q;
  assign fail_addr = fail_addr_q;
  assign fail_data = fail_data_q;
  assign fail_exp  = fail_exp_q;
  assign a1        = a1_q;
  assign d1        = d1_q;
  assign wr1       = wr1_q;
  assign a2        = a2_q;
  assign d2        = d2_q;
  assign wr2       = wr2_q;

endmodule

// File: tb/tb_ram_march_bist.sv
// tb_ram_march_bist: drives the march BIST against behavioural RAMs with
// injectable faults and checks results against an array-based reference model.
module tb_ram_march_bist;

  localparam int unsigned H   = 64;
  localparam int unsigned RDL = 1;
  localparam logic [7:0]  BGV = 8'h55;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, start_b, mon_clr;

  logic       busy, done, pass, fail_port, wr1, wr2;
  logic [6:0] fail_addr, a1, a2;
  logic [7:0] fail_data, fail_exp, d1, d2, q1, q2;

  logic       busy_b, done_b, pass_b, fail_port_b, wr1_b, wr2_b;
  logic [6:0] fail_addr_b, a1_b, a2_b;
  logic [7:0] fail_data_b, fail_exp_b, d1_b, d2_b, q1_b, q2_b, s1a, s1b;

  // Fault configuration: up to two stuck-at-0 read bits, one ignored port-B pattern write.
  logic       st_en   [2];
  logic [6:0] st_addr [2];
  logic [2:0] st_bit  [2];
  logic       ign_en;
  logic [6:0] ign_addr;

  logic [7:0] mem   [128];
  logic [7:0] mem_b [128];

  int n_tests = 0, n_fail = 0;
  int bcnt, wc1, wc2, badwr, bcnt_b;

  ram_march_bist #(.ADDR_W(7), .DATA_W(8), .RD_LAT(1), .BG(8'h55)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
    .fail_port(fail_port), .fail_addr(fail_addr), .fail_data(fail_data),
    .fail_exp(fail_exp), .a1(a1), .d1(d1), .wr1(wr1), .q1(q1),
    .a2(a2), .d2(d2), .wr2(wr2), .q2(q2)
  );

  ram_march_bist #(.ADDR_W(7), .DATA_W(8), .RD_LAT(2), .BG(8'h55)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .fail_port(fail_port_b), .fail_addr(fail_addr_b), .fail_data(fail_data_b),
    .fail_exp(fail_exp_b), .a1(a1_b), .d1(d1_b), .wr1(wr1_b), .q1(q1_b),
    .a2(a2_b), .d2(d2_b), .wr2(wr2_b), .q2(q2_b)
  );

  function automatic logic [7:0] fread(input logic [6:0] ad, input logic [7:0] v);
    logic [7:0] r;
    r = v;
    for (int f = 0; f < 2; f++)
      if (st_en[f] && st_addr[f] == ad) r[st_bit[f]] = 1'b0;
    return r;
  endfunction

  // Single-cycle read RAM with fault injection.
  always @(posedge clk) begin
    if (wr1) mem[a1] <= d1;
    if (wr2 && !(ign_en && a2 == ign_addr && d2 != BGV)) mem[a2] <= d2;
    q1 <= fread(a1, mem[a1]);
    q2 <= fread(a2, mem[a2]);
  end

  // Two-cycle read RAM, fault free.
  always @(posedge clk) begin
    if (wr1_b) mem_b[a1_b] <= d1_b;
    if (wr2_b) mem_b[a2_b] <= d2_b;
    s1a <= mem_b[a1_b]; s1b <= mem_b[a2_b];
    q1_b <= s1a;        q2_b <= s1b;
  end

  // Busy-cycle, write and out-of-window write counters.
  always @(negedge clk) begin
    if (mon_clr) begin
      bcnt = 0; wc1 = 0; wc2 = 0; badwr = 0; bcnt_b = 0;
    end else begin
      if (busy) bcnt++;
      if (wr1) wc1++;
      if (wr2) wc2++;
      if ((wr1 || wr2) && !(busy && ((bcnt >= 1 && bcnt <= H) ||
          (bcnt >= 2*H + RDL + 1 && bcnt <= 3*H + RDL)))) badwr++;
      if (busy_b) bcnt_b++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_faults();
    for (int f = 0; f < 2; f++) begin st_en[f] = 1'b0; st_addr[f] = '0; st_bit[f] = '0; end
    ign_en = 1'b0; ign_addr = '0;
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1; tick(); mon_clr = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  // Reference: replay the march over a plain array and report the first failure.
  task automatic model(output logic e_pass, output logic e_port, output logic [6:0] e_addr,
                       output logic [7:0] e_data, output logic [7:0] e_exp,
                       output int e_busy, output int e_wc);
    logic [7:0] m [128];
    logic [7:0] ra, rb, xa, xb;
    e_pass = 1'b1; e_port = 1'b0; e_addr = '0; e_data = '0; e_exp = '0;
    e_busy = 4*H + 2*RDL; e_wc = 2*H;
    for (int i = 0; i < 128; i++) m[i] = BGV;
    for (int k = 0; k < H; k++) begin
      ra = fread(7'(k), m[k]); rb = fread(7'(H + k), m[H + k]);
      if (ra !== BGV || rb !== BGV) begin
        e_pass = 1'b0; e_busy = H + k + 1 + RDL; e_wc = H; e_exp = BGV;
        if (ra !== BGV) begin e_port = 1'b0; e_addr = 7'(k); e_data = ra; end
        else begin e_port = 1'b1; e_addr = 7'(H + k); e_data = rb; end
        return;
      end
    end
    for (int i = 0; i < 128; i++)
      if (!(ign_en && i >= H && 7'(i) == ign_addr)) m[i] = 8'(i) ^ ~BGV;
    for (int k = 0; k < H; k++) begin
      xa = 8'(H + k) ^ ~BGV; xb = 8'(k) ^ ~BGV;
      ra = fread(7'(H + k), m[H + k]); rb = fread(7'(k), m[k]);
      if (ra !== xa || rb !== xb) begin
        e_pass = 1'b0; e_busy = 3*H + RDL + k + 1 + RDL;
        if (ra !== xa) begin e_port = 1'b0; e_addr = 7'(H + k); e_data = ra; e_exp = xa; end
        else begin e_port = 1'b1; e_addr = 7'(k); e_data = rb; e_exp = xb; end
        return;
      end
    end
  endtask

  task automatic wait_done(output logic got);
    got = 1'b0;
    for (int i = 0; i < 1000 && !got; i++) begin
      @(negedge clk);
      if (done === 1'b1) got = 1'b1;
    end
  endtask

  task automatic check_result(input string nm);
    logic ep, eport, got;
    logic [6:0] ea;
    logic [7:0] ed, ee;
    int eb, ew;
    model(ep, eport, ea, ed, ee, eb, ew);
    wait_done(got);
    check({nm, "/done_seen"}, 64'(got), 64'(1));
    check({nm, "/pass"}, 64'(pass), 64'(ep));
    check({nm, "/fail_fields"}, 64'({fail_port, fail_addr, fail_data, fail_exp}),
          64'({eport, ea, ed, ee}));
    check({nm, "/busy_cycles"}, 64'(bcnt), 64'(eb));
    check({nm, "/writes"}, 64'({wc1, wc2}), 64'({ew, ew}));
    check({nm, "/stray_writes"}, 64'(badwr), 64'(0));
    @(negedge clk);
    check({nm, "/done_one_cycle"}, 64'({done, busy, pass}), 64'({1'b0, 1'b0, ep}));
  endtask

  task automatic run(input string nm);
    repeat ($urandom_range(1, 6)) tick();
    clear_mon();
    pulse_start();
    check_result(nm);
  endtask

  initial begin
    logic got;
    rst = 1'b1; start = 1'b0; start_b = 1'b0; mon_clr = 1'b0;
    clear_faults();
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("reset_outputs", 64'({busy, done, pass, fail_port, fail_addr, fail_data, fail_exp,
                                 a1, d1, wr1, a2, d2, wr2}), 64'(0));

    run("fault_free");

    st_en[0] = 1'b1; st_addr[0] = 7'h05; st_bit[0] = 3'd0;
    run("stuck_05");
    check("stuck_05/spec_vals", 64'({fail_port, fail_addr, fail_data, fail_exp}),
          64'({1'b0, 7'h05, 8'h54, 8'h55}));
    clear_faults();

    ign_en = 1'b1; ign_addr = 7'h50;
    run("ignB_50");
    check("ignB_50/spec_vals", 64'({fail_port, fail_addr, fail_data, fail_exp}),
          64'({1'b0, 7'h50, 8'h55, 8'hFA}));
    clear_faults();

    st_en[0] = 1'b1; st_addr[0] = 7'h03; st_bit[0] = 3'd0;
    st_en[1] = 1'b1; st_addr[1] = 7'h43; st_bit[1] = 3'd2;
    run("dual_03_43");
    check("dual_03_43/prio", 64'({fail_port, fail_addr}), 64'({1'b0, 7'h03}));
    clear_faults();

    for (int t = 0; t < 6; t++) begin
      if ($urandom_range(0, 1) == 0) begin
        st_en[0] = 1'b1; st_addr[0] = 7'($urandom_range(0, 127));
        st_bit[0] = 3'($urandom_range(0, 7));
      end else begin
        ign_en = 1'b1; ign_addr = 7'($urandom_range(64, 127));
      end
      run($sformatf("rand%0d", t));
      clear_faults();
    end

    clear_mon();
    pulse_start();
    repeat (99) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    @(negedge clk);
    check("abort_outputs", 64'({busy, done, pass, fail_port, fail_addr, fail_data, fail_exp,
                                 a1, d1, wr1, a2, d2, wr2}), 64'(0));
    repeat (4) @(negedge clk);
    check("abort_idle", 64'({busy, done, wr1, wr2}), 64'(0));
    run("after_abort");

    clear_mon();
    pulse_start();
    repeat (8) tick();
    pulse_start();
    repeat (189) tick();
    pulse_start();
    check_result("restart_ignored");
    repeat (4) @(negedge clk);
    check("restart_ignored/stays_idle", 64'({busy, done, pass}), 64'({1'b0, 1'b0, 1'b1}));

    clear_mon();
    start_b = 1'b1; tick(); start_b = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 1000 && !got; i++) begin
      @(negedge clk);
      if (done_b === 1'b1) got = 1'b1;
    end
    check("lat2/done_seen", 64'(got), 64'(1));
    check("lat2/pass", 64'(pass_b), 64'(1));
    check("lat2/busy_cycles", 64'(bcnt_b), 64'(4*H + 4));
    check("lat2/fail_fields", 64'({fail_port_b, fail_addr_b, fail_data_b, fail_exp_b}), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
